// File: rtl/pdm_pkg.sv
// Shared constants and width derivation for the PDM-to-PCM CIC decimator.
package pdm_pkg;

  localparam int DECIM_DEF = 64;
  localparam int PCM_W_DEF = 16;
  localparam int ORDER     = 3;

  // Worst-case CIC growth is ORDER*log2(DECIM) bits over a +/-1 input, plus sign and one guard bit.
  function automatic int acc_width(input int decim);
    return ORDER * $clog2(decim) + 2;
  endfunction

endpackage

// File: rtl/pdm_cic_integrator.sv
// One CIC integrator stage: a wrapping accumulator that advances only when enabled.
module pdm_cic_integrator
  import pdm_pkg::*;
#(
  parameter int ACC_W = acc_width(DECIM_DEF)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic signed [ACC_W-1:0] add_i,
  output logic signed [ACC_W-1:0] sum_o
);

  logic signed [ACC_W-1:0] acc_q;

  // sum_o already includes this cycle's addend so a cascade settles within one clock.
  assign sum_o = acc_q + add_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/pdm_decimator.sv
// Third-order CIC decimator turning a 1-bit PDM microphone stream into saturated signed PCM samples.
module pdm_decimator
  import pdm_pkg::*;
#(
  parameter int DECIM = DECIM_DEF,
  parameter int PCM_W = PCM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pdm_ce,
  input  logic             mic_data,
  input  logic             en,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_valid,
  output logic             sat
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int ACC_W = acc_width(DECIM);
  localparam int SHIFT = ORDER * LOG2D + 1 - PCM_W;
  localparam int EXT_W = ACC_W + PCM_W;
  localparam logic signed [EXT_W-1:0] PCM_MAX = EXT_W'((longint'(1) <<< (PCM_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] PCM_MIN = ~PCM_MAX;

  // Reset asserts immediately but leaves on a clock edge, so no flop sees a release mid-cycle.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  logic                    accept;
  logic signed [ACC_W-1:0] sample;
  logic signed [ACC_W-1:0] int1, int2, int3;

  assign accept = pdm_ce & en;
  assign sample = {{(ACC_W - 1){~mic_data}}, 1'b1};

  pdm_cic_integrator #(.ACC_W(ACC_W)) u_int1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (accept),
    .add_i (sample),
    .sum_o (int1)
  );

  pdm_cic_integrator #(.ACC_W(ACC_W)) u_int2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (accept),
    .add_i (int1),
    .sum_o (int2)
  );

  pdm_cic_integrator #(.ACC_W(ACC_W)) u_int3 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (accept),
    .add_i (int2),
    .sum_o (int3)
  );

  logic [LOG2D-1:0]        phase_q, phase_d;
  logic                    frame_end;
  logic signed [ACC_W-1:0] dly1_q, dly2_q, dly3_q;
  logic signed [ACC_W-1:0] comb1, comb2, comb3;
  logic signed [EXT_W-1:0] comb3_ext, scaled;
  logic [PCM_W-1:0]        clipped;
  logic                    clip_hit;
  logic [PCM_W-1:0]        pcm_q, pcm_d;
  logic                    valid_q, valid_d;
  logic                    sat_q, sat_d;

  assign frame_end = accept && (phase_q == LOG2D'(DECIM - 1));
  assign comb1     = int3 - dly1_q;
  assign comb2     = comb1 - dly2_q;
  assign comb3     = comb2 - dly3_q;
  assign comb3_ext = EXT_W'(comb3);

  if (SHIFT >= 0) begin : g_scale_down
    assign scaled = comb3_ext >>> SHIFT;
  end else begin : g_scale_up
    assign scaled = comb3_ext <<< (-SHIFT);
  end

  // NOTE: every always_comb output gets a default first; a path that leaves one unassigned infers a latch.
  always_comb begin
    clipped  = scaled[PCM_W-1:0];
    clip_hit = 1'b0;
    if (scaled > PCM_MAX) begin
      clipped  = PCM_MAX[PCM_W-1:0];
      clip_hit = 1'b1;
    end else if (scaled < PCM_MIN) begin
      clipped  = PCM_MIN[PCM_W-1:0];
      clip_hit = 1'b1;
    end
  end

  always_comb begin
    phase_d = phase_q;
    pcm_d   = pcm_q;
    valid_d = 1'b0;
    sat_d   = sat_q;
    if (accept) begin
      phase_d = phase_q + LOG2D'(1);
    end
    if (frame_end) begin
      pcm_d   = clipped;
      valid_d = 1'b1;
      sat_d   = sat_q | clip_hit;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      dly1_q  <= '0;
      dly2_q  <= '0;
      dly3_q  <= '0;
      pcm_q   <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pcm_q   <= pcm_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      if (frame_end) begin
        dly1_q <= int3;
        dly2_q <= comb1;
        dly3_q <= comb2;
      end
    end
  end

  assign pcm_data  = pcm_q;
  assign pcm_valid = valid_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench: directed patterns plus a random stream, scored against an arithmetic CIC model.
module tb_pdm_decimator;

  localparam int DECIM = 64;
  localparam int PCM_W = 16;
  localparam int ACC_W = 3 * $clog2(DECIM) + 2;
  localparam int SHIFT = 3 * $clog2(DECIM) + 1 - PCM_W;
  localparam longint PCM_MAX = (longint'(1) << (PCM_W - 1)) - 1;
  localparam longint PCM_MIN = -(longint'(1) << (PCM_W - 1));

  logic             clk;
  logic             reset;
  logic             pdm_ce;
  logic             mic_data;
  logic             en;
  logic [PCM_W-1:0] pcm_data;
  logic             pcm_valid;
  logic             sat;

  pdm_decimator #(.DECIM(DECIM), .PCM_W(PCM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .pdm_ce    (pdm_ce),
    .mic_data  (mic_data),
    .en        (en),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: integrator sums and comb history as plain integers.
  longint m_i1, m_i2, m_i3, m_d1, m_d2, m_d3;
  int     m_count;
  longint m_pcm;
  bit     m_sat;
  bit     m_done;

  int     frames_in_phase;
  bit     settle_chk;
  longint settle_val;
  bit     settle_sat_chk;
  bit     settle_sat_val;
  bit     record_mode;
  bit     compare_mode;
  longint ref_q[$];
  bit     rnd_bits[256];

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrapv(input longint v);
    longint m;
    m = v & ((longint'(1) << ACC_W) - 1);
    if (m >= (longint'(1) << (ACC_W - 1))) m = m - (longint'(1) << ACC_W);
    return m;
  endfunction

  task automatic model_reset();
    m_i1 = 0; m_i2 = 0; m_i3 = 0;
    m_d1 = 0; m_d2 = 0; m_d3 = 0;
    m_count = 0; m_pcm = 0; m_sat = 1'b0;
  endtask

  task automatic model_bit(input bit b);
    longint x, c1, c2, c3, s;
    x    = b ? 1 : -1;
    m_i1 = wrapv(m_i1 + x);
    m_i2 = wrapv(m_i2 + m_i1);
    m_i3 = wrapv(m_i3 + m_i2);
    m_count++;
    m_done = 1'b0;
    if (m_count == DECIM) begin
      m_count = 0;
      c1 = wrapv(m_i3 - m_d1); m_d1 = m_i3;
      c2 = wrapv(c1 - m_d2);   m_d2 = c1;
      c3 = wrapv(c2 - m_d3);   m_d3 = c2;
      s  = c3 >>> SHIFT;
      if (s > PCM_MAX) begin s = PCM_MAX; m_sat = 1'b1; end
      if (s < PCM_MIN) begin s = PCM_MIN; m_sat = 1'b1; end
      m_pcm  = s;
      m_done = 1'b1;
    end
  endtask

  // Present one bit on a single pdm_ce cycle, check the following cycle, then idle for gap clocks.
  task automatic send_bit(input bit b, input int gap);
    mic_data = b;
    pdm_ce   = 1'b1;
    @(posedge clk);
    #1;
    pdm_ce   = 1'b0;
    mic_data = 1'($urandom);
    m_done   = 1'b0;
    if (en) model_bit(b);
    check("pcm_valid", pcm_valid, m_done);
    if (m_done) begin
      frames_in_phase++;
      check("pcm_data", $signed(pcm_data), m_pcm);
      check("sat", sat, m_sat);
      if (record_mode) ref_q.push_back(m_pcm);
      if (compare_mode && ref_q.size() > 0) check("pcm_vs_gapfree", $signed(pcm_data), ref_q.pop_front());
      if (settle_chk && frames_in_phase >= 4) begin
        check("settled_pcm", $signed(pcm_data), settle_val);
        if (settle_sat_chk) check("settled_sat", sat, settle_sat_val);
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      check("idle_valid", pcm_valid, 0);
      check("hold_pcm", $signed(pcm_data), m_pcm);
    end
  endtask

  task automatic start_phase(input bit chk, input longint val, input bit sat_chk, input bit sat_val);
    frames_in_phase = 0;
    settle_chk      = chk;
    settle_val      = val;
    settle_sat_chk  = sat_chk;
    settle_sat_val  = sat_val;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    release_reset();
  endtask

  initial begin
    reset = 1'b0; pdm_ce = 1'b0; mic_data = 1'b0; en = 1'b1;
    record_mode = 1'b0; compare_mode = 1'b0;
    model_reset();
    start_phase(1'b0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_pcm", $signed(pcm_data), 0);
    check("reset_valid", pcm_valid, 0);
    check("reset_sat", sat, 0);
    release_reset();

    // Full-scale positive input clips to the top code.
    start_phase(1'b1, PCM_MAX, 1'b1, 1'b1);
    for (int k = 0; k < 512; k++) send_bit(1'b1, 0);
    check("ones_frames", frames_in_phase, 8);

    // Full-scale negative input lands exactly on the bottom code; sat stays sticky.
    start_phase(1'b1, PCM_MIN, 1'b1, 1'b1);
    for (int k = 0; k < 512; k++) send_bit(1'b0, 0);
    check("zeros_frames", frames_in_phase, 8);

    // Reset 40 bits into a frame: outputs clear at once, partial frame is discarded.
    start_phase(1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) send_bit(1'b1, 0);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_pcm", $signed(pcm_data), 0);
    check("midrst_valid", pcm_valid, 0);
    check("midrst_sat", sat, 0);
    model_reset();
    @(posedge clk);
    #1;
    check("midrst_hold_pcm", $signed(pcm_data), 0);
    check("midrst_hold_sat", sat, 0);
    release_reset();

    // Alternating pattern averages to zero without clipping.
    start_phase(1'b1, 0, 1'b1, 1'b0);
    for (int k = 0; k < 512; k++) send_bit((k % 2) == 0, 0);
    check("alt_frames", frames_in_phase, 8);

    // Three ones in four gives half of full scale.
    start_phase(1'b1, 16384, 1'b1, 1'b0);
    for (int k = 0; k < 512; k++) send_bit((k % 4) != 3, 0);
    check("p75_frames", frames_in_phase, 8);

    // Random stream gap-free, then again with random gaps and an en drop mid-frame.
    start_phase(1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 256; k++) rnd_bits[k] = 1'($urandom);
    pulse_reset();
    record_mode = 1'b1;
    for (int k = 0; k < 256; k++) send_bit(rnd_bits[k], 0);
    record_mode = 1'b0;
    check("rnd_ref_frames", ref_q.size(), 4);

    pulse_reset();
    compare_mode = 1'b1;
    for (int k = 0; k < 256; k++) begin
      if (k == 100) begin
        en = 1'b0;
        for (int j = 0; j < 50; j++) send_bit(1'($urandom), 1);
        en = 1'b1;
      end
      send_bit(rnd_bits[k], int'($urandom_range(0, 50)));
    end
    compare_mode = 1'b0;
    check("rnd_ref_consumed", ref_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pdm_decimator.md
PDM_DECIMATOR -- requirements
Module: pdm_decimator

Interface
REQ-001 SHALL have parameter DECIM, default 64, meaning PDM bits per PCM output sample; the only legal value is a power of two in 16..128.
REQ-002 SHALL have parameter PCM_W, default 16, meaning output sample width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port pdm_ce, input, 1 bit: one-clk strobe marking a valid microphone bit, one per mclk period.
REQ-006 SHALL have port mic_data, input, 1 bit: PDM bit, sampled only when pdm_ce=1.
REQ-007 SHALL have port en, input, 1 bit: capture enable.
REQ-008 SHALL have port pcm_data, output, PCM_W bits: signed two's-complement PCM sample.
REQ-009 SHALL have port pcm_valid, output, 1 bit: one-clk strobe qualifying pcm_data.
REQ-010 SHALL have port sat, output, 1 bit: sticky flag, set when any output was clipped.

Function
REQ-011 SHALL map each sampled mic_data bit 1 to +1 and 0 to -1.
REQ-012 SHALL implement a 3-stage CIC decimator (3 integrators, 3 combs, differential delay 1) of rate DECIM.
REQ-013 SHALL use an accumulator width ACC_W = 3*log2(DECIM)+2 bits (20 at default), signed.
REQ-014 SHALL wrap integrators modulo 2^ACC_W with no saturation; combs SHALL use the same width.
REQ-015 SHALL update integrators only on cycles with pdm_ce=1 and en=1; they SHALL hold otherwise.
REQ-016 SHALL count accepted bits with a log2(DECIM)-bit phase counter that wraps from DECIM-1 to 0.
REQ-017 SHALL evaluate the comb chain on the cycle the counter wraps, using the integrator-3 value that includes that bit.
REQ-018 SHALL register pcm_data and pulse pcm_valid for exactly one clk, exactly 1 clk after the pdm_ce cycle of the DECIM-th bit.
REQ-019 SHALL form pcm_data as comb3 arithmetic-shifted right by 3*log2(DECIM)+1-PCM_W bits (3 at default).
REQ-020 SHALL clip that shifted value to [-2^(PCM_W-1), 2^(PCM_W-1)-1] (e.g. +32768 becomes 32767) and set sat in the same cycle.
REQ-021 SHALL hold pcm_data between strobes.
REQ-022 SHALL, when en falls, freeze the counter and integrators; an incomplete frame SHALL be completed once en returns.
REQ-023 SHALL treat pdm_ce asserted on consecutive clks as consecutive valid bits (no minimum gap).
REQ-024 SHALL clear sat only by reset.

Reset
REQ-025 SHALL, while reset=0, asynchronously clear the integrators, comb delays, phase counter, pcm_data, pcm_valid and sat to 0.
REQ-026 SHALL discard a partial frame when reset is asserted mid-frame; the first pcm_valid after release SHALL follow DECIM new accepted bits.
REQ-027 SHALL release reset synchronously with respect to clk.

Structure
REQ-028 SHALL take DECIM default, ORDER=3, ACC_W derivation and PCM_W default from shared package pdm_pkg.
REQ-029 SHALL instantiate sub-module pdm_cic_integrator (one enabled wrapping accumulator) three times; combs SHALL be inline.

Verification
REQ-030 SHALL verify mic_data=1 held for 512 strobes -> pcm_valid every 64 strobes; from the 4th pcm_valid on, pcm_data=32767 and sat=1.
REQ-031 SHALL verify mic_data=0 held -> from the 4th pcm_valid on, pcm_data=-32768 and sat=1.
REQ-032 SHALL verify alternating 1,0 pattern -> settled pcm_data=0 and sat=0.
REQ-033 SHALL verify 75% ones pattern (1,1,1,0) -> settled pcm_data=16384.
REQ-034 SHALL verify reset pulsed low after 40 bits of a frame -> all outputs 0 during reset; next pcm_valid exactly 1 clk after the 64th post-release strobe.
REQ-035 SHALL verify pdm_ce back-to-back and with random gaps of 0..50 clks, plus en dropped for 100 clks mid-frame -> pcm_data sequence identical to the gap-free run.
